// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Decode-stage hazard/flush signal bundle shared by the sequencer
//            and the decode/EX control logic.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;
    logic        dec_valid_in;
    logic [4:0]  rs1_in;
    logic        rs1_read_in;
    logic [4:0]  rs2_in;
    logic        rs2_read_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic        mem_read_in;
    logic        mispredict_in;
    logic        rs_read_out;
    logic        bubble_out;
    logic        flush_out;
    logic [1:0]  state_out;
    logic [31:0] stall_cycles_out;
    logic [15:0] flush_events_out;

    modport master (
        output dec_valid_in, rs1_in, rs1_read_in, rs2_in, rs2_read_in,
               rd_in, rd_write_in, mem_read_in, mispredict_in,
        input  rs_read_out, bubble_out, flush_out, state_out,
               stall_cycles_out, flush_events_out
    );

    modport slave (
        input  dec_valid_in, rs1_in, rs1_read_in, rs2_in, rs2_read_in,
               rd_in, rd_write_in, mem_read_in, mispredict_in,
        output rs_read_out, bubble_out, flush_out, state_out,
               stall_cycles_out, flush_events_out
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Decode-stage interlock and mispredict flush sequencer with
//            stall/flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic         req,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } slot_t;

    localparam logic [3:0] c_flush_init = 4'(FLUSH_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_flush_cnt;
    logic [3:0]  w_flush_cnt_nxt;
    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    slot_t       w_dec_entry;
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_events;
    logic        w_hit1_ex;
    logic        w_hit2_ex;
    logic        w_hit1_mem;
    logic        w_hit2_mem;
    logic        w_hazard;
    logic        w_flush;
    logic        w_stall;
    logic        w_bubble;
    logic        w_unused_ok;

    function automatic logic src_hit(input logic valid, input logic rd_en,
                                     input logic [4:0] rs, input slot_t s);
        return valid & rd_en & (rs != 5'd0) & s.v & (s.rd == rs);
    endfunction

    assign w_dec_entry = {hz.dec_valid_in & hz.rd_write_in & (hz.rd_in != 5'd0),
                          hz.rd_in, hz.mem_read_in};

    assign w_hit1_ex  = src_hit(hz.dec_valid_in, hz.rs1_read_in, hz.rs1_in, r_ex);
    assign w_hit2_ex  = src_hit(hz.dec_valid_in, hz.rs2_read_in, hz.rs2_in, r_ex);
    assign w_hit1_mem = src_hit(hz.dec_valid_in, hz.rs1_read_in, hz.rs1_in, r_mem);
    assign w_hit2_mem = src_hit(hz.dec_valid_in, hz.rs2_read_in, hz.rs2_in, r_mem);

    // With forwarding only a load still in EX cannot supply its result in time.
    generate
        if (FWD_EN) begin : g_fwd
            assign w_hazard = (w_hit1_ex | w_hit2_ex) & r_ex.ld;
        end else begin : g_no_fwd
            assign w_hazard = w_hit1_ex | w_hit2_ex | w_hit1_mem | w_hit2_mem;
        end
    endgenerate

    // WB is kept for visibility only; MEM hits matter only without forwarding.
    assign w_unused_ok = &{1'b0, r_wb, w_hit1_mem, w_hit2_mem};

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_flush         = hz.mispredict_in | (r_state == ST_FLUSH);
        w_stall         = w_hazard & ~w_flush;
        w_bubble        = w_stall | w_flush;

        case (r_state)
            ST_RUN:   if (w_hazard)  w_state_nxt = ST_STALL;
            ST_STALL: if (!w_hazard) w_state_nxt = ST_RUN;
            ST_FLUSH: begin
                if (r_flush_cnt == 4'd0) w_state_nxt = ST_RUN;
                else                     w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
            default:  w_state_nxt = ST_RUN;
        endcase

        if (hz.mispredict_in) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_flush_init;
        end
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_stall_cycles <= 32'd0;
            r_flush_events <= 16'd0;
        end else begin
            r_ex  <= w_bubble ? slot_t'('0) : w_dec_entry;
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (hz.mispredict_in && (r_flush_events != 16'hFFFF))
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign hz.rs_read_out      = w_stall;
    assign hz.bubble_out       = w_bubble;
    assign hz.flush_out        = w_flush;
    assign hz.state_out        = r_state;
    assign hz.stall_cycles_out = r_stall_cycles;
    assign hz.flush_events_out = r_flush_events;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed + random bench for hazard_ctrl, two parameterisations
//            (forwarding / no forwarding) checked against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic req = 1'b0;
    logic reset;
    always #5 req = ~req;

    logic       dv, r1en, r2en, wr, ld, misp;
    logic [4:0] rs1, rs2, rd;

    hazard_ctrl_if hif0 ();
    hazard_ctrl_if hif1 ();

    assign hif0.dec_valid_in = dv;   assign hif1.dec_valid_in = dv;
    assign hif0.rs1_in       = rs1;  assign hif1.rs1_in       = rs1;
    assign hif0.rs1_read_in  = r1en; assign hif1.rs1_read_in  = r1en;
    assign hif0.rs2_in       = rs2;  assign hif1.rs2_in       = rs2;
    assign hif0.rs2_read_in  = r2en; assign hif1.rs2_read_in  = r2en;
    assign hif0.rd_in        = rd;   assign hif1.rd_in        = rd;
    assign hif0.rd_write_in  = wr;   assign hif1.rd_write_in  = wr;
    assign hif0.mem_read_in  = ld;   assign hif1.mem_read_in  = ld;
    assign hif0.mispredict_in = misp; assign hif1.mispredict_in = misp;

    hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_LEN(2)) dut0 (.req(req), .reset(reset), .hz(hif0));
    hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_LEN(3)) dut1 (.req(req), .reset(reset), .hz(hif1));

    logic        o_rs  [2];
    logic        o_bub [2];
    logic        o_fl  [2];
    logic [1:0]  o_st  [2];
    logic [31:0] o_sc  [2];
    logic [15:0] o_fe  [2];
    assign o_rs[0] = hif0.rs_read_out;       assign o_rs[1] = hif1.rs_read_out;
    assign o_bub[0] = hif0.bubble_out;       assign o_bub[1] = hif1.bubble_out;
    assign o_fl[0] = hif0.flush_out;         assign o_fl[1] = hif1.flush_out;
    assign o_st[0] = hif0.state_out;         assign o_st[1] = hif1.state_out;
    assign o_sc[0] = hif0.stall_cycles_out;  assign o_sc[1] = hif1.stall_cycles_out;
    assign o_fe[0] = hif0.flush_events_out;  assign o_fe[1] = hif1.flush_events_out;

    // Reference model: history of what entered EX in the last two cycles,
    // remaining flush cycles, and whether the previous cycle stalled.
    bit          m_fwd [2] = '{1'b1, 1'b0};
    int          m_flen[2] = '{2, 3};
    bit          ex_v [2], mem_v [2], ex_ld [2], mem_ld [2];
    logic [4:0]  ex_rd [2], mem_rd [2];
    int          fl_left [2];
    bit          prev_st [2];
    logic [31:0] m_sc [2];
    int          m_fe [2];
    bit          e_st [2], e_bub [2];

    int n_err = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] rs, input bit en, input bit v,
                               input logic [4:0] prd);
        return dv && en && (rs != 5'd0) && v && (prd == rs);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ex_v[d] = 0; mem_v[d] = 0; ex_ld[d] = 0; mem_ld[d] = 0;
            ex_rd[d] = 5'd0; mem_rd[d] = 5'd0;
            fl_left[d] = 0; prev_st[d] = 0; m_sc[d] = 32'd0; m_fe[d] = 0;
            e_st[d] = 0; e_bub[d] = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit hex, hmem, hzd, fl;
            int est;
            hex  = hit(rs1, r1en, ex_v[d], ex_rd[d]) || hit(rs2, r2en, ex_v[d], ex_rd[d]);
            hmem = hit(rs1, r1en, mem_v[d], mem_rd[d]) || hit(rs2, r2en, mem_v[d], mem_rd[d]);
            hzd  = m_fwd[d] ? (hex && ex_ld[d]) : (hex || hmem);
            fl   = misp || (fl_left[d] > 0);
            e_st[d]  = hzd && !fl;
            e_bub[d] = e_st[d] || fl;
            est = (fl_left[d] > 0) ? 2 : (prev_st[d] ? 1 : 0);
            check($sformatf("dut%0d rs_read", d), 32'(o_rs[d]),  32'(e_st[d]));
            check($sformatf("dut%0d bubble", d),  32'(o_bub[d]), 32'(e_bub[d]));
            check($sformatf("dut%0d flush", d),   32'(o_fl[d]),  32'(fl));
            check($sformatf("dut%0d state", d),   32'(o_st[d]),  32'(est));
            check($sformatf("dut%0d stall_cnt", d), o_sc[d], m_sc[d]);
            check($sformatf("dut%0d flush_cnt", d), 32'(o_fe[d]), 32'(m_fe[d]));
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            if (e_st[d]) m_sc[d] = m_sc[d] + 32'd1;
            if (misp) begin
                fl_left[d] = m_flen[d];
                if (m_fe[d] < 65535) m_fe[d]++;
            end else if (fl_left[d] > 0) begin
                fl_left[d]--;
            end
            prev_st[d] = e_st[d];
            mem_v[d] = ex_v[d]; mem_rd[d] = ex_rd[d]; mem_ld[d] = ex_ld[d];
            ex_v[d]  = !e_bub[d] && dv && wr && (rd != 5'd0);
            ex_rd[d] = rd;
            ex_ld[d] = ld;
        end
    endtask

    // Inputs are set at posedge+1; outputs are checked at the negedge.
    task automatic step();
        #4;
        check_all();
        @(posedge req);
        model_update();
        #1;
    endtask

    task automatic idle();
        dv = 0; r1en = 0; r2en = 0; wr = 0; ld = 0; misp = 0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    task automatic issue(input logic [4:0] a, input logic ae, input logic [4:0] b,
                         input logic be, input logic [4:0] d, input logic de,
                         input logic l);
        dv = 1; rs1 = a; r1en = ae; rs2 = b; r2en = be; rd = d; wr = de; ld = l; misp = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge req);
        #1 reset = 1'b1;

        // Load-use: lw x5 then add reading x5, held while stalled.
        issue(5'd1, 1, 5'd0, 0, 5'd5, 1, 1); step();
        issue(5'd5, 1, 5'd6, 1, 5'd8, 1, 0); step(); step(); step();
        idle(); step(); step();
        check("dut0 loaduse stall total", o_sc[0], 32'd1);
        check("dut1 loaduse stall total", o_sc[1], 32'd2);

        // ALU producer then reader; load to x0 then reader of x0.
        issue(5'd2, 1, 5'd0, 0, 5'd5, 1, 0); step();
        issue(5'd0, 0, 5'd5, 1, 5'd9, 1, 0); step(); step(); step();
        idle(); step(); step();
        issue(5'd3, 1, 5'd0, 0, 5'd0, 1, 1); step();
        issue(5'd0, 1, 5'd0, 1, 5'd4, 1, 0); step(); step();
        idle(); step(); step();
        check("dut0 alu/x0 stall total", o_sc[0], 32'd1);
        check("dut1 alu/x0 stall total", o_sc[1], 32'd4);

        // Single mispredict pulse.
        misp = 1; step();
        misp = 0; for (int i = 0; i < 6; i++) step();
        check("dut0 flush events", 32'(o_fe[0]), 32'd1);

        // Mispredict while a load-use stall is pending.
        issue(5'd1, 1, 5'd0, 0, 5'd5, 1, 1); step();
        issue(5'd5, 1, 5'd0, 0, 5'd6, 1, 0); misp = 1; step();
        idle(); for (int i = 0; i < 6; i++) step();
        check("dut0 stall after misp", o_sc[0], 32'd1);
        check("dut0 flush events 2", 32'(o_fe[0]), 32'd2);

        // Asynchronous reset in the middle of a flush.
        issue(5'd1, 1, 5'd0, 0, 5'd9, 1, 1); step();
        idle(); misp = 1; step();
        misp = 0; step();
        #1 reset = 1'b0;
        model_reset();
        #1 check_all();
        check("dut1 flush during reset", 32'(o_fl[1]), 32'd0);
        #1 reset = 1'b1;
        issue(5'd9, 1, 5'd9, 1, 5'd3, 1, 0); step(); step();
        idle(); step();
        check("dut0 stall after reset", o_sc[0], 32'd0);

        // Random traffic over a small register set to provoke frequent hits.
        for (int i = 0; i < 400; i++) begin
            dv   = ($urandom_range(0, 9) < 8);
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            r1en = 1'($urandom_range(0, 1));
            r2en = 1'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 3) != 0);
            ld   = 1'($urandom_range(0, 1));
            misp = ($urandom_range(0, 11) == 0);
            step();
        end
        idle(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock and flush sequencer for the decode stage.
- Keeps a shadow scoreboard of in-flight destination registers (EX, MEM and WB slots) and compares it against the decode-stage source registers (rs1/rs2 unregistered outputs).
- Drives the decode hold (rs_read), EX bubble insertion and front-end flush after a branch mispredict.
- Maintains stall and flush performance counters.

Parameters:
- FWD_EN, 1: 1 means EX/MEM forwarding exists, so only load-use in EX stalls; 0 means any RAW against EX or MEM stalls.
- FLUSH_LEN, 2: bubble cycles issued after a mispredict (legal range 1..15).

Ports:
- req  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid_in  in  1  the decode-stage instruction is valid (control unit valid).
- rs1_in  in  5  decode rs1 index.
- rs1_read_in  in  1  decode reads rs1.
- rs2_in  in  5  decode rs2 index.
- rs2_read_in  in  1  decode reads rs2.
- rd_in  in  5  decode destination register.
- rd_write_in  in  1  decode instruction writes rd.
- mem_read_in  in  1  decode instruction is a load.
- mispredict_in  in  1  branch resolved mispredicted in EX this cycle.
- rs_read_out  out  1  hold decode/fetch; wired to decode rs_read.
- bubble_out  out  1  force an invalid instruction into EX this cycle.
- flush_out  out  1  squash fetch and decode contents.
- state_out  out  2  0=RUN, 1=STALL, 2=FLUSH.
- stall_cycles_out  out  32  count of cycles with rs_read_out=1.
- flush_events_out  out  16  count of accepted mispredicts.

Behaviour:
- Reset (reset=0, asynchronous):
  - state RUN.
  - All scoreboard slots invalid.
  - Counters 0; flush counter 0.
  - Outputs: rs_read_out=0, bubble_out=0, flush_out=0, state_out=0.
  - Takes effect mid-stall or mid-flush with no further side effects.
- Scoreboard slot contents: {v, rd, ld}.
  - Decode entry: v = dec_valid_in & rd_write_in & (rd_in != 0); ld = mem_read_in.
- Scoreboard update on each rising edge of req:
  - EX <= bubble (v=0) if bubble_out=1, else the decode entry.
  - MEM <= EX.
  - WB <= MEM.
  - The back end never stalls; the WB slot is informational only (the register file is write-through).
- Source match: srcX_hit(S) = dec_valid_in & rsX_read_in & (rsX_in != 0) & S.v & (S.rd == rsX_in).
- Hazard (combinational):
  - FWD_EN=1: any srcX_hit(EX) with EX.ld=1.
  - FWD_EN=0: any srcX_hit(EX) or srcX_hit(MEM).
- Flush condition: flush_out = mispredict_in | (state==FLUSH). Takes priority over hazard.
- Stall condition: rs_read_out = hazard & !flush_out.
- Bubble condition: bubble_out = rs_read_out | flush_out.
- Next-state rules:
  - Any state with mispredict_in=1: go to FLUSH, flush counter <= FLUSH_LEN-1, flush_events_out += 1 (saturates at 0xFFFF). A mispredict during FLUSH restarts the count.
  - RUN: hazard goes to STALL, otherwise stays RUN.
  - STALL: hazard stays STALL, otherwise goes to RUN.
  - FLUSH (no mispredict): if counter==0 go to RUN, else decrement the counter.
- Total flush length is FLUSH_LEN+1 cycles of flush_out: the mispredict cycle plus FLUSH_LEN cycles in FLUSH.
- Hazards are not evaluated during a flush, because the decode contents are squashed.
- stall_cycles_out increments every edge where rs_read_out=1 and wraps modulo 2^32.
- Latency: stall, bubble and flush signals are combinational, in the same cycle as the inputs; the state and counters are registered.
- Boundary rules:
  - rd=0 or rs=0 never creates a hazard.
  - rs1 and rs2 both hitting counts as one stall cycle.
  - A hazard against a stalled (bubbled) producer clears naturally as the producer moves down the slots.

Test Plan:
- FWD_EN=1: lw x5 (ld, rd=5) issued, next decode add reads rs1=5 -> rs_read_out=1 and bubble_out=1 for exactly 1 cycle, state 1 then 0, stall_cycles_out=1.
- FWD_EN=1: addi x5 followed by add reading x5 -> no stall. Load to x0 followed by a reader of x0 -> no stall. Counter stays 0.
- FWD_EN=0: addi x7 then sub reading rs2=7 -> rs_read_out high 2 consecutive cycles, then released; stall_cycles_out=2.
- FLUSH_LEN=2: one-cycle mispredict_in pulse -> flush_out high 3 cycles, bubble_out high 3 cycles, state 2 for 2 cycles then 0, flush_events_out=1.
- Mispredict asserted while stalled on a load-use -> rs_read_out drops the same cycle, flush_out=1, state goes to FLUSH, and the stall counter does not increment that cycle.
- Reset pulled low during FLUSH mid-count -> all outputs 0 immediately (async). After release, a reader of the prior load's rd -> no stall, because the scoreboard was cleared.
